// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory arbiter
package mem_arb_pkg;

  localparam int DATA_W           = 32;
  localparam int DEF_AW           = 30;
  localparam int DEF_DEPTH_WORDS  = 1024;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

  // One outstanding response travelling from grant cycle to done cycle
  typedef struct packed {
    logic  valid;
    port_e port;
    logic  err;
    logic  is_read;
  } pend_t;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational grant selection (fixed priority, or round robin with MEM_ARB_RR_EN)
import mem_arb_pkg::*;

module mem_arb_pick (
`ifdef MEM_ARB_RR_EN
  input  port_e last,
`endif
  input  logic  i_req,
  input  logic  d_req,
  output logic  i_gnt,
  output logic  d_gnt
);

  // Pick at most one requester; on contention either data wins or the least recent loser wins
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (i_req && d_req) begin
`ifdef MEM_ARB_RR_EN
      if (last == PORT_D) begin
        i_gnt = 1'b1;
      end else begin
        d_gnt = 1'b1;
      end
`else
      d_gnt = 1'b1;
`endif
    end else if (d_req) begin
      d_gnt = 1'b1;
    end else if (i_req) begin
      i_gnt = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (fetch/data) arbiter onto one single-port RAM; MEM_ARB_RR_EN selects round robin
import mem_arb_pkg::*;

module mem_arbiter #(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int AW          = DEF_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [AW-1:0]     i_addr,
  output logic              i_gnt,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [AW-1:0]     d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              ram_wren,
  output logic [AW-1:0]     ram_address,
  output logic [DATA_W-1:0] ram_data,
  input  logic [DATA_W-1:0] ram_q
);

  pend_t         pend;
  pend_t         pend_next;
  logic [AW-1:0] gnt_addr;
  logic          gnt_any;
  logic          gnt_in_range;

  function automatic logic in_range(input logic [AW-1:0] a);
    return (64'(a) < 64'(DEPTH_WORDS));
  endfunction

`ifdef MEM_ARB_RR_EN
  port_e last;

  // Remember which port won most recently; fetch is treated as last so data wins first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= PORT_I;
    end else if (gnt_any) begin
      last <= d_gnt ? PORT_D : PORT_I;
    end
  end
`endif

  // Requests are masked during reset so no grant can escape while rst_n is low
  mem_arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
    .last  (last),
`endif
    .i_req (i_req & rst_n),
    .d_req (d_req & rst_n),
    .i_gnt (i_gnt),
    .d_gnt (d_gnt)
  );

  assign gnt_any      = i_gnt | d_gnt;
  assign gnt_addr     = d_gnt ? d_addr : i_addr;
  assign gnt_in_range = in_range(gnt_addr);

  // RAM side: the fetch address is the idle default, writes only for in-range data grants
  always_comb begin
    ram_address = gnt_addr;
    ram_data    = d_wdata;
    ram_wren    = d_gnt & d_we & gnt_in_range;
  end

  // Describe the response owed next cycle for whatever was granted this cycle
  always_comb begin
    pend_next         = '0;
    pend_next.valid   = gnt_any;
    pend_next.port    = d_gnt ? PORT_D : PORT_I;
    pend_next.err     = gnt_any & ~gnt_in_range;
    pend_next.is_read = gnt_any & ~(d_gnt & d_we);
  end

  // Pending-response register; reset discards any response in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
    end else begin
      pend <= pend_next;
    end
  end

  // Deliver the done pulse, error and read data to the owning port only
  always_comb begin
    i_done  = pend.valid & (pend.port == PORT_I);
    d_done  = pend.valid & (pend.port == PORT_D);
    i_err   = i_done & pend.err;
    d_err   = d_done & pend.err;
    i_rdata = (i_done & pend.is_read & ~pend.err) ? ram_q : '0;
    d_rdata = (d_done & pend.is_read & ~pend.err) ? ram_q : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter with a registered-read RAM model
module tb_mem_arbiter;

  localparam int AW = 30;

  logic          clk;
  logic          rst_n;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt;
  logic          i_done;
  logic [31:0]   i_rdata;
  logic          i_err;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic          d_gnt;
  logic          d_done;
  logic [31:0]   d_rdata;
  logic          d_err;
  logic          ram_wren;
  logic [AW-1:0] ram_address;
  logic [31:0]   ram_data;
  logic [31:0]   ram_q;

  logic [31:0]   mem [0:1023];
  logic [31:0]   fetch_exp [0:4];

  int n_cmp;
  int n_bad;

  mem_arbiter #(.DEPTH_WORDS(1024), .AW(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req       (i_req),
    .i_addr      (i_addr),
    .i_gnt       (i_gnt),
    .i_done      (i_done),
    .i_rdata     (i_rdata),
    .i_err       (i_err),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_gnt       (d_gnt),
    .d_done      (d_done),
    .d_rdata     (d_rdata),
    .d_err       (d_err),
    .ram_wren    (ram_wren),
    .ram_address (ram_address),
    .ram_data    (ram_data),
    .ram_q       (ram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM with one-cycle registered read
  always @(posedge clk) begin
    if (ram_wren) mem[ram_address[9:0]] <= ram_data;
    ram_q <= mem[ram_address[9:0]];
  end

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle();
    i_req = 1'b0;
    d_req = 1'b0;
    d_we  = 1'b0;
  endtask

  task automatic drain();
    tick(); idle(); smp();
    tick(); smp();
  endtask

  task automatic reset_pulse();
    tick(); idle(); rst_n = 1'b0;
    tick(); rst_n = 1'b1; smp();
  endtask

  int dones;
  logic exp_d;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    for (int a = 0; a < 1024; a++) mem[a] = 32'h1000_0000 + a;
    fetch_exp[0] = 32'h1000_0000;
    fetch_exp[1] = 32'h1000_0001;
    fetch_exp[2] = 32'h1000_0002;
    fetch_exp[3] = 32'h1000_0003;
    fetch_exp[4] = 32'hDEAD_BEEF;

    // Reset state with both requests asserted: nothing may be granted
    rst_n = 1'b0; i_req = 1'b1; i_addr = '0; d_req = 1'b1; d_we = 1'b1;
    d_addr = 4; d_wdata = 32'h5555_5555;
    smp(); smp();
    expect_eq("rst_i_gnt", i_gnt, 0);
    expect_eq("rst_d_gnt", d_gnt, 0);
    expect_eq("rst_wren", ram_wren, 0);
    expect_eq("rst_dones", {i_done, d_done, i_err, d_err}, 0);
    expect_eq("rst_rdata", i_rdata | d_rdata, 0);
    tick(); idle(); rst_n = 1'b1; smp();

    // Write 0xDEADBEEF to 4, then read it back in the next cycle
    tick(); d_req = 1; d_we = 1; d_addr = 4; d_wdata = 32'hDEAD_BEEF; smp();
    expect_eq("raw_wr_gnt", d_gnt, 1);
    expect_eq("raw_wr_wren", ram_wren, 1);
    expect_eq("raw_wr_addr", ram_address, 4);
    expect_eq("raw_wr_data", ram_data, 32'hDEAD_BEEF);
    tick(); d_we = 0; smp();
    expect_eq("raw_rd_gnt", d_gnt, 1);
    expect_eq("raw_wr_done", d_done, 1);
    expect_eq("raw_rd_wren", ram_wren, 0);
    tick(); idle(); smp();
    expect_eq("raw_rd_done", d_done, 1);
    expect_eq("raw_rd_data", d_rdata, 32'hDEAD_BEEF);
    expect_eq("raw_rd_err", d_err, 0);
    tick(); smp();
    expect_eq("raw_no_extra", d_done, 0);

    reset_pulse();

    // Simultaneous requests: data first, fetch next, dones in order
    tick(); i_req = 1; i_addr = 2; d_req = 1; d_we = 0; d_addr = 8; smp();
    expect_eq("sim_d_gnt", d_gnt, 1);
    expect_eq("sim_i_gnt", i_gnt, 0);
    expect_eq("sim_addr", ram_address, 8);
    tick(); d_req = 0; smp();
    expect_eq("sim_i_gnt2", i_gnt, 1);
    expect_eq("sim_d_done", d_done, 1);
    expect_eq("sim_i_done0", i_done, 0);
    expect_eq("sim_d_rdata", d_rdata, 32'h1000_0008);
    expect_eq("sim_i_rdata0", i_rdata, 0);
    tick(); idle(); smp();
    expect_eq("sim_i_done", i_done, 1);
    expect_eq("sim_i_rdata", i_rdata, 32'h1000_0002);
    expect_eq("sim_d_done0", d_done, 0);
    expect_eq("sim_d_rdata0", d_rdata, 0);
    tick(); smp();

    // Continuous contention for 4 cycles
    dones = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 0) begin
        i_req = 1; i_addr = 1; d_req = 1; d_we = 0; d_addr = 3;
      end
      smp();
`ifdef MEM_ARB_RR_EN
      exp_d = (k % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      expect_eq($sformatf("cont_d_gnt%0d", k), d_gnt, exp_d);
      expect_eq($sformatf("cont_i_gnt%0d", k), i_gnt, !exp_d);
      dones += int'(i_done) + int'(d_done);
    end
    tick(); idle(); smp();
    dones += int'(i_done) + int'(d_done);
    tick(); smp();
    dones += int'(i_done) + int'(d_done);
    expect_eq("cont_dones", dones, 4);

    // Out-of-range write and read at 1024, then confirm word 0 untouched
    tick(); d_req = 1; d_we = 1; d_addr = 1024; d_wdata = 32'h1234; smp();
    expect_eq("oor_wr_gnt", d_gnt, 1);
    expect_eq("oor_wr_wren", ram_wren, 0);
    tick(); d_we = 0; smp();
    expect_eq("oor_rd_gnt", d_gnt, 1);
    expect_eq("oor_wr_done", d_done, 1);
    expect_eq("oor_wr_err", d_err, 1);
    expect_eq("oor_rd_wren", ram_wren, 0);
    tick(); d_addr = 0; smp();
    expect_eq("oor_rd_done", d_done, 1);
    expect_eq("oor_rd_err", d_err, 1);
    expect_eq("oor_rd_data", d_rdata, 0);
    tick(); idle(); smp();
    expect_eq("w0_done", d_done, 1);
    expect_eq("w0_err", d_err, 0);
    expect_eq("w0_data", d_rdata, 32'h1000_0000);
    tick(); smp();

    // Back-to-back fetch of addresses 0..4
    for (int k = 0; k < 5; k++) begin
      tick(); i_req = 1; i_addr = k; smp();
      expect_eq($sformatf("b2b_gnt%0d", k), i_gnt, 1);
      if (k > 0) begin
        expect_eq($sformatf("b2b_done%0d", k - 1), i_done, 1);
        expect_eq($sformatf("b2b_data%0d", k - 1), i_rdata, fetch_exp[k - 1]);
      end
    end
    tick(); idle(); smp();
    expect_eq("b2b_done4", i_done, 1);
    expect_eq("b2b_data4", i_rdata, fetch_exp[4]);
    tick(); smp();
    expect_eq("b2b_end", i_done, 0);

    // Reset arrives the cycle after a fetch grant
    tick(); i_req = 1; i_addr = 5; smp();
    expect_eq("mid_gnt", i_gnt, 1);
    tick(); rst_n = 1'b0; smp();
    expect_eq("mid_rst_out", {i_gnt, d_gnt, i_done, d_done, i_err, d_err, ram_wren}, 0);
    expect_eq("mid_rst_rdata", i_rdata | d_rdata, 0);
    tick(); smp();
    expect_eq("mid_rst_out2", {i_gnt, i_done, ram_wren}, 0);
    tick(); idle(); rst_n = 1'b1; smp();
    expect_eq("mid_rel_done", i_done, 0);
    tick(); smp();
    expect_eq("mid_rel_done2", i_done, 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
